// File: rtl/axis_fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// axis_fifo_uart_pkg
// Shared constants for the UART <-> AXI-Lite byte path:
//   AXI_DATA_WIDTH_UART : width of the UART byte stream (tdata)
//   FIFO_DEPTH_UART     : default depth of the UART stream FIFO
//   FIFO_AFULL_UART     : default almost-full threshold of that FIFO
// Also holds the per-cycle FIFO operation encoding used by the pointer logic.
// ---------------------------------------------------------------------------
package axis_fifo_uart_pkg;

  localparam int AXI_DATA_WIDTH_UART = 8;
  localparam int FIFO_DEPTH_UART     = 16;
  localparam int FIFO_AFULL_UART     = 14;

  // Bit 1 = read handshake, bit 0 = write handshake.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : axis_fifo_uart_pkg

// File: rtl/axis_fifo_uart_if.sv
// ---------------------------------------------------------------------------
// axis_fifo_uart_if
// AXI-Stream byte channel between the UART and the AXI-Lite command logic.
//   tdata  : payload, DATA_WIDTH bits
//   tvalid : source has data
//   tready : sink accepts data
// Modports:
//   master : drives tdata/tvalid, samples tready
//   slave  : samples tdata/tvalid, drives tready
// ---------------------------------------------------------------------------
interface axis_fifo_uart_if #(
  parameter int DATA_WIDTH = axis_fifo_uart_pkg::AXI_DATA_WIDTH_UART
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface : axis_fifo_uart_if

// File: rtl/axis_fifo_uart_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram_uart
// Simple dual-port storage for the UART stream FIFO: one registered write
// port and one asynchronous read port.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinationally mem[raddr_i]
// ---------------------------------------------------------------------------
module sdp_ram_uart #(
  parameter int  DATA_WIDTH = axis_fifo_uart_pkg::AXI_DATA_WIDTH_UART,
  parameter int  DEPTH      = axis_fifo_uart_pkg::FIFO_DEPTH_UART,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset on purpose; a reset on every entry would
  // prevent mapping onto RAM cells, and the FIFO never reads a slot that has
  // not been written since the pointers were last cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : sdp_ram_uart

// File: rtl/axis_fifo_uart.sv
// ---------------------------------------------------------------------------
// axis_fifo_uart
// First-word-fall-through AXI-Stream FIFO that absorbs UART byte bursts while
// the AXI-Lite side is busy. Adds occupancy, almost-full and a synchronous
// flush on top of the plain stream interface.
//   aclk        : clock
//   aresetn     : asynchronous active-low reset
//   flush       : synchronous clear; wins over any same-cycle handshake
//   s_axis      : write side (slave modport: tdata/tvalid in, tready out)
//   m_axis      : read side (master modport: tdata/tvalid out, tready in)
//   count       : occupancy, 0..DEPTH
//   almost_full : count >= AFULL_THRESH
//   empty       : count == 0
//   full        : count == DEPTH
// All status outputs, including both tready/tvalid, decode from the
// registered count only, so no input-to-output combinational path exists.
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module axis_fifo_uart
  import axis_fifo_uart_pkg::*;
#(
  parameter int  DATA_WIDTH   = AXI_DATA_WIDTH_UART,
  parameter int  DEPTH        = FIFO_DEPTH_UART,
  parameter int  AFULL_THRESH = DEPTH - 2,
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 flush,
  axis_fifo_uart_if.slave      s_axis,
  axis_fifo_uart_if.master     m_axis,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q,  count_d;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_op_e              op;

  // Status decode from the registered count.
  assign full        = (count_q == CNT_WIDTH'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_WIDTH'(AFULL_THRESH));
  assign count       = count_q;

  assign s_axis.tready = ~full;
  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = rd_data;

  assign wr_en = s_axis.tvalid & ~full;
  assign rd_en = m_axis.tready & ~empty;
  assign op    = fifo_op_e'({rd_en, wr_en});

  // NOTE: every _d signal takes its hold value before any branch so that no
  // path through this block leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        OP_WR: begin
          wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
          count_d  = count_q + CNT_WIDTH'(1);
        end
        OP_RD: begin
          rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
          count_d  = count_q - CNT_WIDTH'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
          rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flushed write is dropped at the RAM too; the slot stays unused anyway.
  sdp_ram_uart #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .we_i    (wr_en & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis.tdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule : axis_fifo_uart

// File: tb/tb_axis_fifo_uart.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_uart
// Self-checking bench for axis_fifo_uart. A queue of accepted bytes is the
// reference: writes push when fewer than DEPTH bytes are held, reads pop when
// any are held, flush empties it. Every clock the DUT status and head byte are
// compared with it; a vector table and directed sequences add fixed
// expectations for the corner cases.
// ---------------------------------------------------------------------------
module tb_axis_fifo_uart;
  import axis_fifo_uart_pkg::*;

  localparam int DW    = AXI_DATA_WIDTH_UART;
  localparam int DEPTH = FIFO_DEPTH_UART;
  localparam int AFULL = FIFO_AFULL_UART;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk;
  logic          aresetn;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          empty;
  logic          full;

  axis_fifo_uart_if #(.DATA_WIDTH(DW)) s_if ();
  axis_fifo_uart_if #(.DATA_WIDTH(DW)) m_if ();

  axis_fifo_uart #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .flush       (flush),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .count       (count),
    .almost_full (almost_full),
    .empty       (empty),
    .full        (full)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q[$];

  typedef struct {
    logic          f;
    logic          tv;
    logic [DW-1:0] td;
    logic          tr;
    int            exp_count;
    logic          exp_tvalid;
    logic [DW-1:0] exp_tdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = model_q.size();
    check("count",       32'(count),       32'(n));
    check("empty",       32'(empty),       32'(n == 0));
    check("full",        32'(full),        32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AFULL));
    check("s_tready",    32'(s_if.tready), 32'(n < DEPTH));
    check("m_tvalid",    32'(m_if.tvalid), 32'(n > 0));
    if (n > 0) check("m_tdata", 32'(m_if.tdata), 32'(model_q[0]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"},    32'(count),       32'd0);
    check({tag, "_empty"},    32'(empty),       32'd1);
    check({tag, "_full"},     32'(full),        32'd0);
    check({tag, "_afull"},    32'(almost_full), 32'd0);
    check({tag, "_s_tready"}, 32'(s_if.tready), 32'd1);
    check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
  endtask

  // Drive one clock of stimulus (called at posedge+1), advance the model with
  // the pre-edge occupancy, then compare after the edge.
  task automatic cycle(input logic f, input logic tv, input logic [DW-1:0] td, input logic tr);
    bit wr, rd;
    flush       = f;
    s_if.tvalid = tv;
    s_if.tdata  = td;
    m_if.tready = tr;
    wr = tv && (model_q.size() < DEPTH);
    rd = tr && (model_q.size() > 0);
    if (f) begin
      model_q.delete();
    end else begin
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back(td);
    end
    @(posedge aclk);
    #1;
    check_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wprob, rprob;

    //            f  tv  td     tr  cnt tvalid tdata
    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
    vecs[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 3, 1'b1, 8'h11};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h22};
    vecs[5] = '{1'b0, 1'b1, 8'h44, 1'b1, 2, 1'b1, 8'h33};
    vecs[6] = '{1'b1, 1'b1, 8'h55, 1'b1, 0, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 8'h66, 1'b0, 1, 1'b1, 8'h66};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    aresetn     = 1'b0;
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check_reset_vals("reset");
    aresetn = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Vector table: first-word fall-through, hold, read, read+write, flush.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].f, vecs[i].tv, vecs[i].td, vecs[i].tr);
      check("vec_count",  32'(count),       32'(vecs[i].exp_count));
      check("vec_tvalid", 32'(m_if.tvalid), 32'(vecs[i].exp_tvalid));
      if (vecs[i].exp_tvalid) check("vec_tdata", 32'(m_if.tdata), 32'(vecs[i].exp_tdata));
    end

    // Fill to DEPTH, then a held 17th byte accepted only after one read.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, DW'(8'h80 + i), 1'b0);
      if (i == AFULL - 2) check("afull_below", 32'(almost_full), 32'd0);
      if (i == AFULL - 1) check("afull_at",    32'(almost_full), 32'd1);
    end
    check("full_at_depth",   32'(full),        32'd1);
    check("tready_when_full", 32'(s_if.tready), 32'd0);
    cycle(1'b0, 1'b1, 8'hF0, 1'b0);
    cycle(1'b0, 1'b1, 8'hF0, 1'b0);
    check("held_count", 32'(count), 32'(DEPTH));
    cycle(1'b0, 1'b1, 8'hF0, 1'b1);
    check("no_passthru_count", 32'(count), 32'(DEPTH - 1));
    cycle(1'b0, 1'b1, 8'hF0, 1'b0);
    check("held_accepted", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("drained_empty", 32'(empty), 32'd1);

    // Continuous stream across two pointer wraps.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, DW'(i), 1'b1);
      check("stream_count", 32'(count), 32'd1);
      check("stream_head",  32'(m_if.tdata), 32'(i));
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Flush at count 5 with a simultaneous write and read.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DW'(8'hC0 + i), 1'b0);
    check("pre_flush_count", 32'(count), 32'd5);
    cycle(1'b1, 1'b1, 8'hAA, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("post_flush_tvalid", 32'(m_if.tvalid), 32'd0);
    end
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    check("post_flush_head", 32'(m_if.tdata), 32'h5A);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset in mid-cycle at count 9.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, DW'(8'hD0 + i), 1'b0);
    check("pre_reset_count", 32'(count), 32'd9);
    #3;
    aresetn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_q.delete();
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    @(posedge aclk);
    #1;
    check_reset_vals("reset_held");
    aresetn = 1'b1;
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 1'b1, 8'h3D, 1'b0);
    check("after_reset_first", 32'(m_if.tdata), 32'h3C);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("after_reset_second", 32'(m_if.tdata), 32'h3D);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomised traffic: filling, draining and balanced phases.
    for (int c = 0; c < 600; c++) begin
      case ((c / 100) % 3)
        0:       begin wprob = 90; rprob = 20; end
        1:       begin wprob = 20; rprob = 90; end
        default: begin wprob = 60; rprob = 60; end
      endcase
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 99) < wprob,
            DW'($urandom),
            $urandom_range(0, 99) < rprob);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_axis_fifo_uart

// File: doc/axis_fifo_uart.md
Name: axis_fifo_uart

Overview:
- Parametrised AXI-Stream FIFO between the UART receiver/transmitter byte streams and the AXI-Lite master command logic.
- Absorbs bursts of UART bytes while the AXI-Lite side is busy.
- Adds depth, occupancy reporting, an almost-full threshold and a synchronous flush, none of which the plain stream interface provides.
- First-word-fall-through: head data is presented on the master side without a read request.

Parameters:
- DATA_WIDTH, AXI_DATA_WIDTH_UART (package constant, 8): tdata width in bits.
- DEPTH, 16: number of entries. Must be a power of two and at least 2.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH. Legal range is 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH+1): width of the count output. Derived; must not be overridden.

Ports:
- aclk  in  1  single clock for the whole block.
- aresetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO contents.
- s_axis_tdata  in  DATA_WIDTH  write data.
- s_axis_tvalid  in  1  write data valid.
- s_axis_tready  out  1  FIFO can accept data.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO data.
- m_axis_tvalid  out  1  head data is valid.
- m_axis_tready  in  1  downstream accepts the head word.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Clock and reset: one clock (aclk). Reset (aresetn) is asynchronous and active-low. All state is clocked on the rising edge of aclk.
- Reset values:
  - Pointers and count are cleared.
  - Outputs: s_axis_tready=1, m_axis_tvalid=0, count=0, almost_full=0, empty=1, full=0.
  - m_axis_tdata is don't-care. The storage array is not reset.
- Write: occurs when s_axis_tvalid && s_axis_tready at the clock edge. Data goes to mem[wr_ptr] and wr_ptr increments.
- Read: occurs when m_axis_tvalid && m_axis_tready at the clock edge. rd_ptr increments.
- Pointers: log2(DEPTH) bits wide; they wrap naturally from DEPTH-1 to 0.
- Status decoding:
  - s_axis_tready = !full.
  - m_axis_tvalid = !empty.
  - All status outputs decode from the registered count only; there is no combinational path from tvalid or tready inputs to any output.
- Latency: a word written into an empty FIFO appears on m_axis_tvalid/m_axis_tdata in the next cycle.
- No pass-through: when full, no write is accepted even if a read happens in the same cycle.
- No bypass: when empty, there is no same-cycle path from s_axis to m_axis.
- Simultaneous read and write while not empty and not full: both pointers advance and count is unchanged.
- count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- Data stability: m_axis_tdata = mem[rd_ptr] (asynchronous read). It must stay stable while m_axis_tvalid=1 and m_axis_tready=0, because rd_ptr does not move and the slot at rd_ptr is never written while count>0.
- Flush:
  - On the next edge, pointers and count go to 0.
  - Flush dominates: a write or read handshake in the same cycle is discarded and no pointer advances from it.
  - The write-side handshake still completes from the sender's point of view (tready was 1), so the byte is dropped.
- AXI-Stream rules:
  - The source must not drop tvalid or change tdata before the handshake; this block is not required to check it.
  - This block never deasserts m_axis_tvalid without a read or flush.
- Reset mid-operation: asserting aresetn low immediately clears all state, independent of aclk. Deassertion is synchronised externally.

Decomposition:
- The existing AXI-Lite package holds:
  - AXI_DATA_WIDTH_UART.
  - New constant FIFO_DEPTH_UART = 16.
  - New constant FIFO_AFULL_UART = 14.
- Sub-module sdp_ram_uart: simple dual-port storage with a registered write and an asynchronous read, parameterised by DATA_WIDTH and DEPTH, with no reset.
- axis_fifo_uart holds the pointers, the counter and the status decode.
- The top level may bind the flattened ports to the UART stream interface modports (s_axis on the input side, m_axis on the output side).

Test Plan:
- Reset then idle -> s_axis_tready=1, m_axis_tvalid=0, count=0, empty=1, full=0, almost_full=0.
- Write 0x11,0x22,0x33 with m_axis_tready=0 -> count goes 1,2,3; m_axis_tvalid rises the cycle after the 0x11 write; m_axis_tdata holds 0x11 throughout.
- Fill to 16 with m_axis_tready=0 -> almost_full=1 at count=14; full=1 and s_axis_tready=0 at 16; a 17th byte is held (not lost) until one read occurs, then accepted.
- Continuous write and read with both ready=1 over 40 bytes (0x00..0x27, crosses pointer wrap twice) -> output order 0x00..0x27, count steady at 1 after start-up.
- At count=5, assert flush together with a write of 0xAA and a read -> next cycle count=0, empty=1; 0xAA never appears at the output.
- Assert aresetn=0 mid-burst at count=9, asynchronously to aclk -> outputs return to reset values before the next aclk edge; after release, the first written byte is the first read.
